apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, sets the PADDR width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, sets the PWDATA/PRDATA width; legal values are 8, 16, 32.
REQ-003 Parameter NUM_REGS, default 16, sets the register count; legal range 4..256.
REQ-004 Parameter WAIT_STATES, default 1, sets the number of PREADY-low access cycles; legal range 0..15.
REQ-005 Parameter ID_VALUE, default 32'hA9B0_0001, is the constant read from register 0.
REQ-006 PCLK  in  1  the single clock; all logic is sampled on the rising edge.
REQ-007 PRESET  in  1  synchronous, active-high reset.
REQ-008 PSEL  in  1  APB select.
REQ-009 PENABLE  in  1  APB access phase.
REQ-010 PWRITE  in  1  1 = write, 0 = read.
REQ-011 PADDR  in  ADDR_WIDTH  byte address.
REQ-012 PWDATA  in  DATA_WIDTH  write data.
REQ-013 PRDATA  out  DATA_WIDTH  read data.
REQ-014 PREADY  out  1  transfer completion.
REQ-015 PSLVERR  out  1  transfer error, valid only while PREADY=1.
REQ-016 status_i  in  DATA_WIDTH  hardware status, readable at register 1.
REQ-017 regs_o  out  NUM_REGS*DATA_WIDTH  flattened register file; slice k holds register k.
REQ-018 wr_pulse_o  out  1  one-cycle pulse when an RW register is written.
REQ-019 wr_index_o  out  8  index of the register written; valid while wr_pulse_o=1.

Function
REQ-020 The state machine SHALL have three states: ST_IDLE, ST_WAIT and ST_RESP.
REQ-021 ST_IDLE SHALL go to ST_WAIT on PSEL=1 and PENABLE=0 (setup phase) and SHALL capture PADDR, PWRITE and PWDATA in that cycle.
REQ-022 ST_WAIT SHALL load a counter with WAIT_STATES, decrement it each cycle, and go to ST_RESP when it reaches 0.
REQ-023 If WAIT_STATES=0, the transition from ST_WAIT to ST_RESP SHALL be immediate, giving PREADY=1 in the first access cycle.
REQ-024 PREADY SHALL be registered and SHALL be 1 for exactly one cycle: the (WAIT_STATES+1)-th cycle after the setup cycle. ST_RESP then returns to ST_IDLE.
REQ-025 Register index SHALL be PADDR[clog2(DATA_WIDTH/8) +: clog2(NUM_REGS)].
REQ-026 Any set bit in PADDR[clog2(DATA_WIDTH/8)-1:0] SHALL be a misaligned error.
REQ-027 A PADDR at or above NUM_REGS*DATA_WIDTH/8 SHALL be an out-of-range error.
REQ-028 A write to register 0 or register 1 SHALL be a read-only error.
REQ-029 PSLVERR SHALL be 1 in the PREADY cycle when any error applies, and 0 in every other cycle.
REQ-030 An error write SHALL modify no register and SHALL NOT pulse wr_pulse_o.
REQ-031 An error read SHALL return PRDATA=0.
REQ-032 A valid read SHALL drive PRDATA in the PREADY cycle as follows:
  - register 0: ID_VALUE truncated to DATA_WIDTH;
  - register 1: status_i sampled at the setup cycle;
  - register k (k >= 2): its current value.
REQ-033 PRDATA SHALL be 0 whenever PREADY=0.
REQ-034 A valid write SHALL update register k on the clock edge that ends the PREADY cycle.
REQ-035 wr_pulse_o=1 and wr_index_o=k SHALL be asserted in the cycle immediately after that edge.
REQ-036 If PSEL drops while in ST_WAIT, the transfer SHALL abort: return to ST_IDLE, no register write, no PREADY.
REQ-037 PENABLE=1 while in ST_IDLE, without a preceding setup cycle, SHALL be ignored.
REQ-038 Back-to-back transfers SHALL be supported: a new setup in the cycle after the PREADY cycle is accepted.
REQ-039 Throughput SHALL be one transfer per WAIT_STATES+2 cycles.
REQ-040 regs_o slices 0 and 1 SHALL mirror ID_VALUE and status_i combinationally; slices >= 2 SHALL be flop outputs.

Reset
REQ-041 While PRESET=1, the block SHALL hold: state ST_IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wr_pulse_o=0, wr_index_o=0, wait counter 0, all RW registers 0.
REQ-042 PRESET asserted mid-transfer SHALL abandon the transfer with no register write; the block is ready for a setup in the first cycle after PRESET deasserts.

Verification
REQ-043 Scenario: defaults, write 0xDEADBEEF to address 0x08, then read 0x08.
  - Write: PREADY=1 exactly 2 cycles after setup, PSLVERR=0, wr_pulse_o=1 with wr_index_o=2.
  - Read: PRDATA=0xDEADBEEF.
REQ-044 Scenario: read 0x00, then read 0x04 with status_i=0x55.
  - PRDATA=0xA9B00001, then PRDATA=0x00000055, PSLVERR=0 both times.
REQ-045 Scenario: write 0x09 (misaligned), 0x40 (out of range with NUM_REGS=16), and 0x04 (read-only).
  - Each gives PSLVERR=1 with PREADY, no wr_pulse_o, and register contents unchanged.
REQ-046 Scenario: WAIT_STATES=0 and 3, back-to-back writes.
  - PREADY arrives at setup+1 and setup+4 respectively; the next setup is accepted in the cycle after PREADY.
REQ-047 Scenario: PSEL dropped during the second wait cycle (WAIT_STATES=3).
  - No PREADY, no write; the next full transfer completes normally.
REQ-048 Scenario: PRESET pulsed for one cycle mid-write.
  - All outputs 0, target register unchanged, and the following transfer succeeds.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB register slave: a parameterised register file behind an APB completer.
// Register 0 is a constant ID and register 1 mirrors hardware status; both are
// read-only. Registers 2 and up are RW flops.
// Every accepted transfer takes WAIT_STATES+2 cycles: one setup cycle, then
// WAIT_STATES cycles with PREADY low, then one cycle with PREADY high.
module apb_reg_slave #(
    parameter int          ADDR_WIDTH  = 13,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [DATA_WIDTH-1:0]          status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           wr_pulse_o,
    output logic [7:0]                     wr_index_o
);

    // Number of byte-offset bits below the register index.
    localparam int ALIGN = $clog2(DATA_WIDTH / 8);
    // Number of bits in the register index.
    localparam int IDXW  = $clog2(NUM_REGS);
    // Mask that selects the byte-offset bits of an address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    // First byte address past the end of the register file.
    localparam logic [ADDR_WIDTH:0]   BYTE_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * (DATA_WIDTH / 8));

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                               state;
    logic [3:0]                           wait_cnt;
    logic [ADDR_WIDTH-1:0]                addr_q;
    logic                                 wr_q;
    logic [DATA_WIDTH-1:0]                wdata_q;
    logic [DATA_WIDTH-1:0]                status_q;
    logic [NUM_REGS-1:2][DATA_WIDTH-1:0]  rw_q;

    // Decode inputs. With no wait states the response is computed at the
    // setup edge itself, so the decoder looks at the live bus in ST_IDLE and
    // at the captured copy in every other state.
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  dec_wr;
    logic [DATA_WIDTH-1:0] dec_status;
    logic [IDXW-1:0]       idx;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] rd_data;

    // Address decode, error classification and read-data mux.
    always_comb begin
        dec_addr   = (state == ST_IDLE) ? PADDR    : addr_q;
        dec_wr     = (state == ST_IDLE) ? PWRITE   : wr_q;
        dec_status = (state == ST_IDLE) ? status_i : status_q;
        idx        = dec_addr[ALIGN +: IDXW];
        acc_err    = (|(dec_addr & ALIGN_MASK))
                   | ({1'b0, dec_addr} >= BYTE_LIMIT)
                   | (dec_wr && (idx < IDXW'(2)));
        rd_data    = '0;
        if (idx == IDXW'(0)) begin
            rd_data = ID_VALUE[DATA_WIDTH-1:0];
        end else if (idx == IDXW'(1)) begin
            rd_data = dec_status;
        end
        for (int k = 2; k < NUM_REGS; k++) begin
            if (idx == IDXW'(k)) begin
                rd_data = rw_q[k];
            end
        end
    end

    // Transfer FSM with registered APB response and register-file update.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            status_q   <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            PRDATA     <= '0;
            wr_pulse_o <= 1'b0;
            wr_index_o <= '0;
            rw_q       <= '0;
        end else begin
            wr_pulse_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A lone PENABLE without a setup cycle is not a transfer.
                    if (PSEL && !PENABLE) begin
                        addr_q   <= PADDR;
                        wr_q     <= PWRITE;
                        wdata_q  <= PWDATA;
                        status_q <= status_i;
                        if (WAIT_STATES == 0) begin
                            // No wait cycles: respond in the first access cycle.
                            wait_cnt <= '0;
                            state    <= ST_RESP;
                            PREADY   <= 1'b1;
                            PSLVERR  <= acc_err;
                            PRDATA   <= (acc_err || PWRITE) ? '0 : rd_data;
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        // Master withdrew the transfer: drop it silently.
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state   <= ST_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= acc_err;
                            PRDATA  <= (acc_err || wr_q) ? '0 : rd_data;
                        end
                    end
                end
                ST_RESP: begin
                    // PSLVERR still holds this transfer's error flag here.
                    if (wr_q && !PSLVERR) begin
                        for (int k = 2; k < NUM_REGS; k++) begin
                            if (idx == IDXW'(k)) begin
                                rw_q[k] <= wdata_q;
                            end
                        end
                        wr_pulse_o <= 1'b1;
                        wr_index_o <= 8'(idx);
                    end
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-only slices are live mirrors; RW slices come straight from flops.
    assign regs_o[0 +: DATA_WIDTH]                        = ID_VALUE[DATA_WIDTH-1:0];
    assign regs_o[DATA_WIDTH +: DATA_WIDTH]               = status_i;
    assign regs_o[NUM_REGS*DATA_WIDTH-1:2*DATA_WIDTH]     = rw_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances share one APB bus, with separate
// PSEL lines, at WAIT_STATES = 1, 0 and 3. Each transfer pushes its expected
// response to a scoreboard, and the entry is popped when PREADY rises.
module tb_apb_reg_slave;

    localparam int WS_T [3] = '{1, 0, 3};
    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        pulse;
        logic [7:0]  idx;
    } exp_t;

    logic        clk;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [12:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] status;
    logic [31:0] prdata   [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [511:0] regs    [3];
    logic [2:0]  wr_pulse;
    logic [7:0]  wr_index [3];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_reg_slave #(.WAIT_STATES(WS_T[g])) u_dut (
            .PCLK       (clk),
            .PRESET     (preset),
            .PSEL       (psel[g]),
            .PENABLE    (penable),
            .PWRITE     (pwrite),
            .PADDR      (paddr),
            .PWDATA     (pwdata),
            .PRDATA     (prdata[g]),
            .PREADY     (pready[g]),
            .PSLVERR    (pslverr[g]),
            .status_i   (status),
            .regs_o     (regs[g]),
            .wr_pulse_o (wr_pulse[g]),
            .wr_index_o (wr_index[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Must be called at a negedge; drives the setup cycle there and returns at
    // the negedge of the cycle after PREADY, ready for a back-to-back setup.
    task automatic xfer(input int d, input bit wr, input logic [12:0] addr,
                        input logic [31:0] wd, input bit err, input logic [31:0] rd);
        exp_t e;
        exp_t o;
        int   lat;
        e.rdata = (wr || err) ? 32'h0 : rd;
        e.err   = err;
        e.lat   = WS_T[d] + 1;
        e.pulse = wr && !err;
        e.idx   = 8'(addr >> 2);
        sb.push_back(e);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        lat = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            penable = 1'b1;
            if (pready[d]) begin
                lat = i;
                break;
            end
            chk("wait_quiet", prdata[d] | 32'(pslverr[d]), 32'h0);
        end
        o = sb.pop_front();
        chk("latency", 32'(lat), 32'(o.lat));
        if (lat != 0) begin
            chk("pslverr", 32'(pslverr[d]), 32'(o.err));
            chk("prdata", prdata[d], o.rdata);
        end
        psel[d] = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("pready_one_cycle", 32'(pready[d]), 32'h0);
        chk("wr_pulse", 32'(wr_pulse[d]), 32'(o.pulse));
        if (o.pulse) chk("wr_index", 32'(wr_index[d]), 32'(o.idx));
    endtask

    initial begin
        preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; status = 32'h1234_5678;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready",  32'(pready[d]),   32'h0);
            chk("rst_pslverr", 32'(pslverr[d]),  32'h0);
            chk("rst_prdata",  prdata[d],        32'h0);
            chk("rst_pulse",   32'(wr_pulse[d]), 32'h0);
            chk("rst_index",   32'(wr_index[d]), 32'h0);
            chk("rst_reg2",    regs[d][2*32 +: 32], 32'h0);
            chk("rst_reg15",   regs[d][15*32 +: 32], 32'h0);
        end
        chk("mirror_id",     regs[0][0 +: 32],  ID);
        chk("mirror_status", regs[0][32 +: 32], 32'h1234_5678);
        preset = 1'b0;
        @(negedge clk);

        // Basic write then read-back, default wait states.
        xfer(0, 1, 13'h008, 32'hDEAD_BEEF, 0, 32'h0);
        chk("reg2_written", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
        xfer(0, 0, 13'h008, 32'h0, 0, 32'hDEAD_BEEF);

        // Read-only registers.
        status = 32'h0000_0055;
        xfer(0, 0, 13'h000, 32'h0, 0, ID);
        xfer(0, 0, 13'h004, 32'h0, 0, 32'h0000_0055);

        // Error writes and reads leave the register file alone.
        xfer(0, 1, 13'h009, 32'h1111_1111, 1, 32'h0);
        xfer(0, 1, 13'h040, 32'h2222_2222, 1, 32'h0);
        xfer(0, 1, 13'h004, 32'h3333_3333, 1, 32'h0);
        xfer(0, 0, 13'h044, 32'h0, 1, 32'h0);
        xfer(0, 0, 13'h00A, 32'h0, 1, 32'h0);
        chk("err_reg2_kept", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
        chk("err_id_kept",   regs[0][0 +: 32],    ID);

        // PENABLE in idle without a setup cycle is ignored.
        psel[0] = 1'b1; penable = 1'b1; paddr = 13'h008; pwrite = 1'b1; pwdata = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lone_penable", {30'h0, pready[0], wr_pulse[0]}, 32'h0);
        end
        psel[0] = 1'b0; penable = 1'b0;
        chk("lone_penable_reg", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
        @(negedge clk);

        // Back-to-back writes with zero and three wait states.
        xfer(1, 1, 13'h00C, 32'h0000_1111, 0, 32'h0);
        xfer(1, 1, 13'h010, 32'h0000_2222, 0, 32'h0);
        xfer(1, 0, 13'h00C, 32'h0, 0, 32'h0000_1111);
        xfer(1, 0, 13'h010, 32'h0, 0, 32'h0000_2222);
        xfer(2, 1, 13'h00C, 32'hAAAA_0003, 0, 32'h0);
        xfer(2, 1, 13'h03C, 32'hBBBB_000F, 0, 32'h0);
        xfer(2, 0, 13'h03C, 32'h0, 0, 32'hBBBB_000F);

        // PSEL withdrawn in the second wait cycle aborts the write.
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h014; pwdata = 32'h0BAD_0BAD;
        @(negedge clk);
        penable = 1'b1;
        chk("abort_w1", 32'(pready[2]), 32'h0);
        @(negedge clk);
        psel[2] = 1'b0; penable = 1'b0;
        chk("abort_w2", 32'(pready[2]), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_quiet", {30'h0, pready[2], wr_pulse[2]}, 32'h0);
        end
        chk("abort_reg5", regs[2][5*32 +: 32], 32'h0);
        xfer(2, 1, 13'h014, 32'h0000_600D, 0, 32'h0);
        xfer(2, 0, 13'h014, 32'h0, 0, 32'h0000_600D);

        // One-cycle reset in the middle of a write.
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h018; pwdata = 32'hCAFE_F00D;
        @(negedge clk);
        penable = 1'b1; preset = 1'b1;
        @(negedge clk);
        preset = 1'b0; psel[0] = 1'b0; penable = 1'b0;
        chk("mid_rst_pready",  32'(pready[0]),   32'h0);
        chk("mid_rst_pslverr", 32'(pslverr[0]),  32'h0);
        chk("mid_rst_prdata",  prdata[0],        32'h0);
        chk("mid_rst_pulse",   32'(wr_pulse[0]), 32'h0);
        chk("mid_rst_index",   32'(wr_index[0]), 32'h0);
        chk("mid_rst_reg6",    regs[0][6*32 +: 32], 32'h0);
        chk("mid_rst_reg2",    regs[0][2*32 +: 32], 32'h0);
        xfer(0, 1, 13'h018, 32'h1357_9BDF, 0, 32'h0);
        xfer(0, 0, 13'h018, 32'h0, 0, 32'h1357_9BDF);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
